// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX checksum trailer appender.
package fix_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BODY,
        S_T1,
        S_T0,
        S_EQ,
        S_D2,
        S_D1,
        S_D0,
        S_TSOH
    } state_t;

    localparam logic [7:0] SOH  = 8'h01;
    localparam logic [7:0] ONE  = 8'h31;
    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] EQ   = 8'h3D;

    // "10=" + three digits + SOH
    localparam int TRAILER_LEN = 7;

endpackage

// File: rtl/bin2ascii3.sv
// Combinational binary-to-three-ASCII-digit converter (hundreds, tens, units).
module bin2ascii3
    import fix_pkg::*;
(
    input  logic [7:0] bin_i,
    output logic [7:0] hund_o,
    output logic [7:0] tens_o,
    output logic [7:0] units_o
);

    always_comb begin
        hund_o  = ZERO + (bin_i / 8'd100);
        tens_o  = ZERO + ((bin_i / 8'd10) % 8'd10);
        units_o = ZERO + (bin_i % 8'd10);
    end

endmodule

// File: rtl/checksum_append.sv
// Passes a FIX message through a registered output stage and appends the
// "10=nnn<SOH>" checksum trailer computed over every message byte.
//
// state  | meaning
// S_IDLE | waiting for a byte flagged start_i
// S_BODY | inside a message, summing bytes
// S_T1   | emit '1'
// S_T0   | emit '0'
// S_EQ   | emit '='
// S_D2   | emit hundreds digit
// S_D1   | emit tens digit
// S_D0   | emit units digit
// S_TSOH | emit trailer SOH with end_o, back to idle
module checksum_append
    import fix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       start_i,
    input  logic       end_i,
    output logic       ready_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       start_o,
    output logic       end_o,
    output logic [7:0] checksum_o,
    output logic       error_o
);

    state_t     state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] ck_q, ck_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       start_q, start_d;
    logic       end_q, end_d;
    logic       err_q, err_d;

    logic       out_free;
    logic       in_acc;
    logic       load;
    logic [7:0] load_data;
    logic       load_start;
    logic       load_end;
    logic [7:0] acc;
    logic [7:0] dig_h, dig_t, dig_u;

    // Digits follow the latched checksum, which is stable for the whole trailer.
    bin2ascii3 u_bin2ascii3 (
        .bin_i   (ck_q),
        .hund_o  (dig_h),
        .tens_o  (dig_t),
        .units_o (dig_u)
    );

    always_comb begin
        out_free   = !valid_q || ready_i;
        ready_o    = ((state_q == S_IDLE) || (state_q == S_BODY)) && out_free;
        in_acc     = valid_i && ready_o;

        state_d    = state_q;
        sum_d      = sum_q;
        ck_d       = ck_q;
        err_d      = 1'b0;
        load       = 1'b0;
        load_data  = data_q;
        load_start = 1'b0;
        load_end   = 1'b0;
        acc        = start_i ? data_i : sum_q + data_i;

        case (state_q)
            S_IDLE, S_BODY: begin
                if (in_acc) begin
                    if (!start_i && (state_q == S_IDLE)) begin
                        err_d = 1'b1;
                    end else begin
                        // A start inside a body abandons the old message.
                        err_d      = start_i && (state_q == S_BODY);
                        sum_d      = acc;
                        load       = 1'b1;
                        load_data  = data_i;
                        load_start = start_i;
                        if (end_i) begin
                            ck_d    = acc;
                            state_d = S_T1;
                        end else begin
                            state_d = S_BODY;
                        end
                    end
                end
            end
            S_T1: if (out_free) begin load = 1'b1; load_data = ONE;  state_d = S_T0; end
            S_T0: if (out_free) begin load = 1'b1; load_data = ZERO; state_d = S_EQ; end
            S_EQ: if (out_free) begin load = 1'b1; load_data = EQ;   state_d = S_D2; end
            S_D2: if (out_free) begin load = 1'b1; load_data = dig_h; state_d = S_D1; end
            S_D1: if (out_free) begin load = 1'b1; load_data = dig_t; state_d = S_D0; end
            S_D0: if (out_free) begin load = 1'b1; load_data = dig_u; state_d = S_TSOH; end
            S_TSOH: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = SOH;
                    load_end  = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        data_d  = data_q;
        valid_d = valid_q;
        start_d = start_q;
        end_d   = end_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
            start_d = load_start;
            end_d   = load_end;
        end else if (out_free) begin
            valid_d = 1'b0;
            start_d = 1'b0;
            end_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= 8'h00;
            ck_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ck_q    <= ck_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign start_o    = start_q;
    assign end_o      = end_q;
    assign checksum_o = ck_q;
    assign error_o    = err_q;

endmodule

// File: tb/tb_checksum_append.sv
// Directed bench for checksum_append: message/trailer vectors plus backpressure,
// framing-error and reset corner sequences.
module tb_checksum_append;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i, start_i, end_i, ready_o;
    logic [7:0] data_o;
    logic       valid_o, ready_i, start_o, end_o;
    logic [7:0] checksum_o;
    logic       error_o;

    always #5 clk = ~clk;

    checksum_append dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .start_i    (start_i),
        .end_i      (end_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .start_o    (start_o),
        .end_o      (end_o),
        .checksum_o (checksum_o),
        .error_o    (error_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } ob_t;

    typedef struct packed {
        logic [3:0]  n;
        logic [47:0] b;   // first byte in the top octet
        logic [7:0]  ck;
        logic [23:0] dg;  // hundreds, tens, units ASCII
    } vec_t;

    ob_t  out_q[$];
    ob_t  exp_q[$];
    vec_t vecs[7];
    int   n_vec = 0;
    int   n_err = 0;
    int   err_cnt = 0;

    // Record every completed output handshake and every error pulse.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) out_q.push_back({data_o, start_o, end_o});
        if (!rst && error_o) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        data_i  = d;
        start_i = s;
        end_i   = e;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("send_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        start_i = 1'b0;
        end_i   = 1'b0;
    endtask

    task automatic send_msg(input vec_t v);
        for (int i = 0; i < int'(v.n); i++)
            send_byte(v.b[47-8*i -: 8], i == 0, i == int'(v.n) - 1);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic s, input logic e);
        exp_q.push_back({d, s, e});
    endtask

    task automatic push_trailer(input logic [23:0] dg);
        push_exp(8'h31, 1'b0, 1'b0);
        push_exp(8'h30, 1'b0, 1'b0);
        push_exp(8'h3D, 1'b0, 1'b0);
        push_exp(dg[23:16], 1'b0, 1'b0);
        push_exp(dg[15:8], 1'b0, 1'b0);
        push_exp(dg[7:0], 1'b0, 1'b0);
        push_exp(8'h01, 1'b0, 1'b1);
    endtask

    task automatic build_exp(input vec_t v);
        exp_q.delete();
        for (int i = 0; i < int'(v.n); i++) push_exp(v.b[47-8*i -: 8], i == 0, 1'b0);
        push_trailer(v.dg);
    endtask

    task automatic wait_end(output logic rdy);
        int   n = 0;
        logic found = 1'b0;
        rdy = 1'b0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (valid_o && ready_i && end_o) begin
                found = 1'b1;
                rdy   = ready_o;
            end
        end
        check("end_seen", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_byte(input logic [7:0] val);
        int   n = 0;
        logic found = 1'b0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (valid_o && data_o == val) found = 1'b1;
        end
        check($sformatf("wait_byte_%0h", val), {31'd0, found}, 32'd1);
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_len"}, out_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < out_q.size()) begin
                check($sformatf("%s_b%0d_data", tag, i), {24'd0, out_q[base+i].d}, {24'd0, exp_q[i].d});
                check($sformatf("%s_b%0d_start", tag, i), {31'd0, out_q[base+i].s}, {31'd0, exp_q[i].s});
                check($sformatf("%s_b%0d_end", tag, i), {31'd0, out_q[base+i].e}, {31'd0, exp_q[i].e});
            end
        end
    endtask

    initial begin
        int   base;
        int   e0;
        logic rdy;

        vecs[0] = '{4'd3, 48'h414201_000000, 8'd132, 24'h313332};
        vecs[1] = '{4'd3, 48'hFFFF03_000000, 8'd1,   24'h303031};
        vecs[2] = '{4'd1, 48'h01_0000000000, 8'd1,   24'h303031};
        vecs[3] = '{4'd4, 48'h10203040_0000, 8'd160, 24'h313630};
        vecs[4] = '{4'd2, 48'h7B00_00000000, 8'd123, 24'h313233};
        vecs[5] = '{4'd1, 48'hFF_0000000000, 8'd255, 24'h323535};
        vecs[6] = '{4'd2, 48'h0000_00000000, 8'd0,   24'h303030};

        rst = 1'b1; data_i = 8'h00; valid_i = 1'b0; start_i = 1'b0; end_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_data_o", {24'd0, data_o}, 32'd0);
        check("rst_checksum_o", {24'd0, checksum_o}, 32'd0);
        check("rst_start_end_err", {29'd0, start_o, end_o, error_o}, 32'd0);
        check("rst_ready_o", {31'd0, ready_o}, 32'd1);
        @(posedge clk); #1;

        // Back-to-back messages; ready_o must be up as the trailer SOH leaves.
        for (int k = 0; k < 7; k++) begin
            base = out_q.size();
            e0   = err_cnt;
            build_exp(vecs[k]);
            send_msg(vecs[k]);
            wait_end(rdy);
            check_stream($sformatf("v%0d", k), base);
            check($sformatf("v%0d_checksum", k), {24'd0, checksum_o}, {24'd0, vecs[k].ck});
            check($sformatf("v%0d_no_error", k), err_cnt - e0, 32'd0);
            check($sformatf("v%0d_ready_at_end", k), {31'd0, rdy}, 32'd1);
        end

        // Byte without start in IDLE: dropped, one error pulse.
        base = out_q.size();
        e0   = err_cnt;
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("idle_drop_err", err_cnt - e0, 32'd1);
        check("idle_drop_noout", out_q.size() - base, 32'd0);

        // Restart inside BODY: old message abandoned, trailer for sum 0x43.
        base = out_q.size();
        e0   = err_cnt;
        exp_q.delete();
        push_exp(8'h41, 1'b1, 1'b0);
        push_exp(8'h42, 1'b0, 1'b0);
        push_exp(8'h43, 1'b1, 1'b0);
        push_trailer(24'h303637);
        send_byte(8'h41, 1'b1, 1'b0);
        send_byte(8'h42, 1'b0, 1'b0);
        send_byte(8'h43, 1'b1, 1'b1);
        wait_end(rdy);
        check_stream("restart", base);
        check("restart_err", err_cnt - e0, 32'd1);
        check("restart_checksum", {24'd0, checksum_o}, 32'h43);

        // Backpressure for 3 cycles while the tens digit is presented.
        base = out_q.size();
        build_exp(vecs[0]);
        send_msg(vecs[0]);
        wait_byte(8'h3D);
        @(negedge clk);
        check("bp_d2_shown", {24'd0, data_o}, 32'h31);
        @(posedge clk); #1 ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_data", c), {24'd0, data_o}, 32'h33);
            check($sformatf("bp_hold%0d_valid", c), {31'd0, valid_o}, 32'd1);
            check($sformatf("bp_hold%0d_ready_o", c), {31'd0, ready_o}, 32'd0);
        end
        @(posedge clk); #1 ready_i = 1'b1;
        wait_end(rdy);
        check_stream("bp", base);
        check("bp_checksum", {24'd0, checksum_o}, 32'd132);

        // Reset while in EQ, then a clean message 41,01 -> "066".
        send_msg(vecs[0]);
        wait_byte(8'h30);
        rst = 1'b1;
        @(negedge clk);
        check("rst_eq_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_eq_idle_ready", {31'd0, ready_o}, 32'd1);
        check("rst_eq_checksum", {24'd0, checksum_o}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        base = out_q.size();
        exp_q.delete();
        push_exp(8'h41, 1'b1, 1'b0);
        push_exp(8'h01, 1'b0, 1'b0);
        push_trailer(24'h303636);
        send_byte(8'h41, 1'b1, 1'b0);
        send_byte(8'h01, 1'b0, 1'b1);
        wait_end(rdy);
        check_stream("post_rst", base);
        check("post_rst_checksum", {24'd0, checksum_o}, 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
